// File: rtl/sync_memory.sv
// sync_memory: single-port, word-addressed synchronous RAM behind a valid/ready handshake.
// Build option: define MEM_RESET_CLEAR_EN to make reset also zero every word of mem.
module sync_memory #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int ADDR  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDR-1:0]  addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wrbar,
  output logic [WIDTH-1:0] rdata,
  input  logic             valid,
  output logic             ready
);

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             accept;
  logic             in_range;
  logic             wr_en;

  // Plain array so masters and benches can reach it hierarchically as dut.mem.
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_comb begin
    in_range = (32'(addr) < DEPTH);
    accept   = (state_q == IDLE) && valid;
    wr_en    = accept && wrbar && in_range;
    state_d  = state_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DONE;
          if (!wrbar) begin
            rdata_d = in_range ? mem[addr] : '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset blocks any write on its edge; only the clear build touches the array then.
`ifdef MEM_RESET_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[addr] <= wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[addr] <= wdata;
    end
  end
`endif

  assign ready = (state_q == DONE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_sync_memory.sv
// tb_sync_memory: randomized self-checking bench for sync_memory against an array model.
// A second, smaller instance (DEPTH=200) exercises out-of-range addresses.
module tb_sync_memory;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        wrbar;
  logic [31:0] rdata;
  logic        valid;
  logic        ready;

  logic [7:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_wrbar;
  logic [31:0] s_rdata;
  logic        s_valid;
  logic        s_ready;

  int checks;
  int failures;

  logic [31:0] model_mem [256];
  logic [31:0] model_rdata;
  logic [31:0] s_model_mem [200];
  logic [31:0] s_model_rdata;

  sync_memory #(.WIDTH(32), .DEPTH(256), .ADDR(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wrbar(wrbar),
    .rdata(rdata), .valid(valid), .ready(ready)
  );

  sync_memory #(.WIDTH(32), .DEPTH(200), .ADDR(8)) dut_small (
    .clk(clk), .rst(rst), .addr(s_addr), .wdata(s_wdata), .wrbar(s_wrbar),
    .rdata(s_rdata), .valid(s_valid), .ready(s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transfer on the main instance; called at posedge+1 with state IDLE.
  task automatic transfer(input logic [7:0] a, input logic we, input logic [31:0] d);
    addr = a; wrbar = we; wdata = d; valid = 1'b1;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_before_accept addr=%0d got=%b want=0", a, ready);
    end
    @(posedge clk); #1;
    if (we) model_mem[a] = d;
    else    model_rdata = model_mem[a];
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_pulse addr=%0d got=%b want=1", a, ready);
    end
    if (!we) begin
      checks++;
      if (rdata !== model_rdata) begin
        failures++;
        $display("[TB] FAIL read_data addr=%0d got=%h want=%h", a, rdata, model_rdata);
      end
    end
    valid = 1'b0; addr = 8'($urandom); wdata = $urandom; wrbar = 1'($urandom);
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || rdata !== model_rdata) begin
      failures++;
      $display("[TB] FAIL ready_drop addr=%0d got ready=%b rdata=%h want ready=0 rdata=%h",
               a, ready, rdata, model_rdata);
    end
  endtask

  // Same as transfer, for the DEPTH=200 instance where addresses >= 200 are out of range.
  task automatic s_transfer(input logic [7:0] a, input logic we, input logic [31:0] d);
    s_addr = a; s_wrbar = we; s_wdata = d; s_valid = 1'b1;
    @(posedge clk); #1;
    if (we) begin
      if (a < 200) s_model_mem[a] = d;
    end else begin
      s_model_rdata = (a < 200) ? s_model_mem[a] : 32'h0;
    end
    checks++;
    if (s_ready !== 1'b1 || s_rdata !== s_model_rdata) begin
      failures++;
      $display("[TB] FAIL small_transfer addr=%0d we=%b got ready=%b rdata=%h want ready=1 rdata=%h",
               a, we, s_ready, s_rdata, s_model_rdata);
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL small_ready_drop addr=%0d got=%b want=0", a, s_ready);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = $urandom;
      dut.mem[i]   = model_mem[i];
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
`ifdef MEM_RESET_CLEAR_EN
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
`endif
    model_rdata = 32'h0;
    checks++;
    if (ready !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got ready=%b rdata=%h want ready=0 rdata=0", ready, rdata);
    end
    for (int i = 0; i < 256; i += 37) begin
      checks++;
      if (dut.mem[i] !== model_mem[i]) begin
        failures++;
        $display("[TB] FAIL reset_array addr=%0d got=%h want=%h", i, dut.mem[i], model_mem[i]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got ready=%b rdata=%h want ready=0 rdata=0", ready, rdata);
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 32; i++) transfer(8'(i), 1'b1, $urandom);
    for (int i = 0; i < 32; i++) transfer(8'(i), 1'b0, $urandom);
  endtask

  task automatic test_backdoor_read();
    for (int i = 0; i < 128; i++) begin
      model_mem[i] = $urandom;
      dut.mem[i]   = model_mem[i];
    end
    for (int i = 0; i < 128; i++) transfer(8'(i), 1'b0, 32'h0);
  endtask

  task automatic test_write_dump();
    for (int i = 0; i < 256; i++) transfer(8'(i), 1'b1, $urandom);
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (dut.mem[i] !== model_mem[i]) begin
        failures++;
        $display("[TB] FAIL dump addr=%0d got=%h want=%h", i, dut.mem[i], model_mem[i]);
      end
    end
  endtask

  task automatic test_handshake_hold();
    logic [7:0]  a;
    logic [31:0] d;
    int          pulses;
    a = 8'($urandom); d = $urandom; pulses = 0;
    addr = a; wdata = d; wrbar = 1'b1; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) pulses++;
      checks++;
      if (ready !== ((i % 2) == 0)) begin
        failures++;
        $display("[TB] FAIL hold_ready cycle=%0d got=%b want=%b", i, ready, (i % 2) == 0);
      end
    end
    valid = 1'b0;
    model_mem[a] = d;
    checks++;
    if (pulses != 3 || dut.mem[a] !== d || rdata !== model_rdata) begin
      failures++;
      $display("[TB] FAIL hold_summary got pulses=%0d mem=%h rdata=%h want pulses=3 mem=%h rdata=%h",
               pulses, dut.mem[a], rdata, d, model_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a;
    logic        we;
    logic [31:0] d;
    a = 8'($urandom_range(0, 7)); we = 1'($urandom); d = $urandom;
    addr = a; wrbar = we; wdata = d; valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (we) model_mem[a] = d;
      else    model_rdata = model_mem[a];
      checks++;
      if (ready !== 1'b1 || rdata !== model_rdata) begin
        failures++;
        $display("[TB] FAIL b2b_accept op=%0d addr=%0d got ready=%b rdata=%h want ready=1 rdata=%h",
                 k, a, ready, rdata, model_rdata);
      end
      a = 8'($urandom_range(0, 7)); we = 1'($urandom); d = $urandom;
      addr = a; wrbar = we; wdata = d;
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b0 || rdata !== model_rdata) begin
        failures++;
        $display("[TB] FAIL b2b_done op=%0d got ready=%b rdata=%h want ready=0 rdata=%h",
                 k, ready, rdata, model_rdata);
      end
    end
    @(posedge clk); #1;
    valid = 1'b0;
    if (we) model_mem[a] = d;
    else    model_rdata = model_mem[a];
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0]  a;
    logic [31:0] d;
    a = 8'($urandom); d = $urandom;
    addr = a; wdata = d; wrbar = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    model_mem[a] = d;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_accept got=%b want=1", ready);
    end
    rst = 1'b1; wdata = ~d;
    @(posedge clk); #1;
`ifdef MEM_RESET_CLEAR_EN
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
`endif
    model_rdata = 32'h0;
    checks++;
    if (ready !== 1'b0 || rdata !== 32'h0 || dut.mem[a] !== model_mem[a]) begin
      failures++;
      $display("[TB] FAIL mid_reset got ready=%b rdata=%h mem=%h want ready=0 rdata=0 mem=%h",
               ready, rdata, dut.mem[a], model_mem[a]);
    end
    rst = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    transfer(a, 1'b0, 32'h0);
  endtask

  task automatic test_out_of_range();
    s_valid = 1'b0;
    @(posedge clk); #1;
    s_transfer(8'd199, 1'b1, $urandom | 32'h1);
    s_transfer(8'd5, 1'b1, $urandom | 32'h1);
    s_transfer(8'd199, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) s_transfer(8'($urandom_range(200, 255)), 1'b1, $urandom);
    s_transfer(8'd5, 1'b0, 32'h0);
    s_transfer(8'($urandom_range(200, 255)), 1'b0, 32'h0);
    s_transfer(8'd199, 1'b0, 32'h0);
    checks++;
    if (dut_small.mem[199] !== s_model_mem[199] || dut_small.mem[5] !== s_model_mem[5]) begin
      failures++;
      $display("[TB] FAIL small_array got m199=%h m5=%h want m199=%h m5=%h",
               dut_small.mem[199], dut_small.mem[5], s_model_mem[199], s_model_mem[5]);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wrbar = 1'b0;
    s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_wrbar = 1'b0;
    model_rdata = 32'h0; s_model_rdata = 32'h0;
    #1;
    test_reset();
    test_write_read();
    test_backdoor_read();
    test_write_dump();
    test_handshake_hold();
    test_back_to_back();
    test_reset_mid();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_memory.md
# sync_memory

Single-port, word-addressed synchronous RAM with a valid/ready request handshake. The bus master presents an address, a direction and write data, and holds `valid` high. The block completes one read or write and pulses `ready` for one cycle. The storage array is a plain register array named `mem`, so testbenches can preload and dump it hierarchically as `dut.mem` with `$readmemh`/`$writememb`. The block sits behind any simple master (CPU load/store stage, DMA, testbench driver) as local data storage.

## Interface
- `WIDTH`, 32: data word width in bits.
- `DEPTH`, 256: number of words; array `mem[0:DEPTH-1]`, each `WIDTH` bits.
- `ADDR`, 8: address width; must satisfy 2^ADDR >= DEPTH.

Ports, in positional order:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  ADDR  word address of the request.
- `wdata`  in  WIDTH  write data, sampled on the accepting edge.
- `wrbar`  in  1  direction: 1 = write, 0 = read.
- `rdata`  out  WIDTH  registered read data.
- `valid`  in  1  request present.
- `ready`  out  1  one-cycle completion strobe.

## Operation
- Two states, encoded by the `ready` register: IDLE (`ready`=0) and DONE (`ready`=1).
- IDLE with `valid`=1 at the rising edge: the request is accepted, and `ready` goes to 1.
  - Write (`wrbar`=1): `mem[addr]` takes `wdata`.
  - Read (`wrbar`=0): `rdata` takes `mem[addr]`.
- IDLE with `valid`=0: no change.
- DONE: `ready` returns to 0 unconditionally. Inputs are ignored on this edge, even if `valid` is still high.
- `rdata` holds its last read value through writes, idle cycles and the DONE cycle.
- Out-of-range address (`addr` >= DEPTH):
  - Write is discarded.
  - Read returns 0.
  - `ready` still pulses normally.
- Reset:
  - `ready` <= 0 and `rdata` <= 0.
  - Array contents are retained unless the configuration macro is enabled.
  - Reset overrides any request on the same edge; a transfer in DONE is simply cut short.
- Backdoor accesses to `mem` are legal at any time. The block keeps no shadow copy or cache of the array.

## Timing
- Latency: request accepted on edge N; `ready`=1 and read data valid from edge N to edge N+1; `ready`=0 after edge N+1.
- Maximum throughput: one transfer per 2 cycles with `valid` held high continuously.
- The master must keep `addr`/`wdata`/`wrbar` stable from assertion of `valid` until it sees `ready`=1.
- The master may change request fields in the `ready` cycle, because the block ignores inputs in DONE.
- Read-after-write to the same address on consecutive transfers returns the new data (no bypass hazard, because of the 2-cycle spacing).
- After reset deasserts, the first request may be accepted on the next edge.

## Configuration
- `MEM_RESET_CLEAR_EN` defined: reset also clears every `mem` location to 0 in the same edge.
- `MEM_RESET_CLEAR_EN` undefined: reset leaves `mem` untouched, so backdoor loads made before or during reset survive.

## Test plan
- Reset then idle:
  - Hold `rst`=1 for 2 cycles.
  - Expect `ready`=0 and `rdata`=0.
  - Expect no array change with the macro off.
- Frontdoor write then read:
  - Write `$random` values to addresses 0..31, then read 0..31.
  - Each `rdata` equals the written word.
  - `ready` pulses exactly once per transfer, 1 cycle after `valid`.
- Backdoor write then frontdoor read:
  - `$readmemh` `image.hex` into `mem[0:127]`, then read 0..127.
  - `rdata` matches the file.
- Frontdoor write then backdoor dump:
  - Write 256 words, then `$writememb` `mem[0:255]`.
  - The dump equals the written values in order.
- Handshake hold:
  - Keep `valid`=1 with the same write for 6 cycles.
  - Exactly 3 `ready` pulses occur, in alternate cycles.
- Reset mid-transfer:
  - Assert `rst` in the DONE cycle.
  - `ready`=0 next cycle.
  - `mem` is cleared only when `MEM_RESET_CLEAR_EN` is defined.
